// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared definitions for the forwarding/hazard controller: register width,
// operand-select encodings and the layout of one in-flight tracking entry.
package fwd_hazard_ctrl_pkg;

    localparam int REG_AW = 2;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dest;
        logic              reg_write;
        logic              mem_read;
    } trk_entry_t;

    // True when the tracked instruction will write register r.
    function automatic logic writes_reg(input trk_entry_t e, input logic [REG_AW-1:0] r);
        return e.valid && e.reg_write && (e.dest == r);
    endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_sel_gen.sv
// Per-operand forward selector: picks the nearest in-flight producer of src.
// Purely combinational; the caller registers the result and applies bubbles.
module fwd_sel_gen
    import fwd_hazard_ctrl_pkg::*;
(
    input  logic [REG_AW-1:0] src_i,
    input  logic              used_i,
    input  trk_entry_t        ex_e_i,
    input  trk_entry_t        mem_e_i,
    output logic [1:0]        sel_nxt_o
);

    always_comb begin
        sel_nxt_o = FWD_RF;
        if (used_i && writes_reg(ex_e_i, src_i)) begin
            sel_nxt_o = FWD_MEM;
        end else if (used_i && writes_reg(mem_e_i, src_i)) begin
            sel_nxt_o = FWD_WB;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard control for the 5-stage pipeline.
// Operand selects are registered (valid while the consumer sits in EX); stall is combinational.
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    output logic              stall,
    output logic [1:0]        fwd_sel_a,
    output logic [1:0]        fwd_sel_b,
    output logic [CNT_W-1:0]  stall_count
);

    trk_entry_t       ex_q, mem_q, wb_q;
    trk_entry_t       ex_d;
    logic [1:0]       sel_a_q, sel_b_q;
    logic [1:0]       sel_a_d, sel_b_d;
    logic [1:0]       sel_a_nxt, sel_b_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bubble;

    // A load still in EX cannot forward its data yet, so a dependent ID
    // instruction waits one cycle; a flushed ID instruction never stalls.
    assign stall = id_valid && !flush && ex_q.mem_read &&
                   ((id_rs_used && writes_reg(ex_q, id_rs)) ||
                    (id_rt_used && writes_reg(ex_q, id_rt)));

    assign bubble = stall || flush || !id_valid;

    fwd_sel_gen u_sel_a (
        .src_i     (id_rs),
        .used_i    (id_rs_used),
        .ex_e_i    (ex_q),
        .mem_e_i   (mem_q),
        .sel_nxt_o (sel_a_nxt)
    );

    fwd_sel_gen u_sel_b (
        .src_i     (id_rt),
        .used_i    (id_rt_used),
        .ex_e_i    (ex_q),
        .mem_e_i   (mem_q),
        .sel_nxt_o (sel_b_nxt)
    );

    always_comb begin
        ex_d    = '0;
        sel_a_d = FWD_RF;
        sel_b_d = FWD_RF;
        if (!bubble) begin
            ex_d.valid     = 1'b1;
            ex_d.dest      = id_dest;
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;
            sel_a_d        = sel_a_nxt;
            sel_b_d        = sel_b_nxt;
        end
        cnt_d = cnt_q;
        if (stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            sel_a_q <= FWD_RF;
            sel_b_q <= FWD_RF;
            cnt_q   <= '0;
        end else begin
            wb_q    <= mem_q;
            mem_q   <= ex_q;
            ex_q    <= ex_d;
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fwd_sel_a   = sel_a_q;
    assign fwd_sel_b   = sel_b_q;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed and random stimulus for fwd_hazard_ctrl against a history-based reference model.
module tb_fwd_hazard_ctrl;

    // Narrow counter so saturation is reachable in a short run.
    localparam int TB_CNT_W = 10;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                id_valid = 1'b0;
    logic [1:0]          id_rs = '0, id_rt = '0, id_dest = '0;
    logic                id_rs_used = 1'b0, id_rt_used = 1'b0;
    logic                id_reg_write = 1'b0, id_mem_read = 1'b0, flush = 1'b0;
    logic                stall;
    logic [1:0]          fwd_sel_a, fwd_sel_b;
    logic [TB_CNT_W-1:0] stall_count;

    int errors = 0;
    int checks = 0;

    fwd_hazard_ctrl #(.CNT_W(TB_CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rs_used   (id_rs_used),
        .id_rt_used   (id_rt_used),
        .id_dest      (id_dest),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .stall        (stall),
        .fwd_sel_a    (fwd_sel_a),
        .fwd_sel_b    (fwd_sel_b),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    // Reference: history of instructions that entered EX, indexed by age
    // (1 = entered on the last edge, 2 = the edge before). Bubbles are invalid.
    bit h_v[1:2];
    int h_dest[1:2];
    bit h_rw[1:2];
    bit h_mr[1:2];
    int exp_sel_a, exp_sel_b, exp_cnt;
    bit exp_stall;

    function automatic bit produces(int age, int r);
        return h_v[age] && h_rw[age] && (h_dest[age] == r);
    endfunction

    function automatic int pick_src(bit used, int r);
        if (!used) return 0;
        for (int age = 1; age <= 2; age++)
            if (produces(age, r)) return age;  // age 1 -> 01, age 2 -> 10
        return 0;
    endfunction

    task automatic model_reset();
        for (int k = 1; k <= 2; k++) begin
            h_v[k] = 0; h_dest[k] = 0; h_rw[k] = 0; h_mr[k] = 0;
        end
        exp_sel_a = 0; exp_sel_b = 0; exp_cnt = 0; exp_stall = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One ID-stage cycle: drive, check combinational stall, clock, check registered outputs.
    task automatic step(input bit v, input int rs, input int rt, input bit ru, input bit rtu,
                        input int d, input bit rw, input bit mr, input bit fl);
        bit bub;
        @(negedge clk);
        id_valid = v; id_rs = rs[1:0]; id_rt = rt[1:0]; id_rs_used = ru; id_rt_used = rtu;
        id_dest = d[1:0]; id_reg_write = rw; id_mem_read = mr; flush = fl;
        exp_stall = v && !fl && h_v[1] && h_mr[1] && h_rw[1] &&
                    ((ru && h_dest[1] == rs) || (rtu && h_dest[1] == rt));
        #1;
        chk("stall", {31'b0, stall}, {31'b0, exp_stall});
        bub = exp_stall || fl || !v;
        exp_sel_a = bub ? 0 : pick_src(ru, rs);
        exp_sel_b = bub ? 0 : pick_src(rtu, rt);
        if (exp_stall && exp_cnt < CNT_MAX) exp_cnt++;
        h_v[2] = h_v[1]; h_dest[2] = h_dest[1]; h_rw[2] = h_rw[1]; h_mr[2] = h_mr[1];
        h_v[1] = !bub; h_dest[1] = d; h_rw[1] = rw; h_mr[1] = mr;
        @(posedge clk);
        #1;
        chk("fwd_sel_a", {30'b0, fwd_sel_a}, exp_sel_a);
        chk("fwd_sel_b", {30'b0, fwd_sel_b}, exp_sel_b);
        chk("stall_count", {{(32-TB_CNT_W){1'b0}}, stall_count}, exp_cnt);
    endtask

    initial begin
        model_reset();
        #2;
        chk("rst_stall", {31'b0, stall}, 0);
        chk("rst_sel_a", {30'b0, fwd_sel_a}, 0);
        chk("rst_sel_b", {30'b0, fwd_sel_b}, 0);
        chk("rst_count", {{(32-TB_CNT_W){1'b0}}, stall_count}, 0);
        @(negedge clk);
        reset = 1'b0;

        // ADD r1 ; ADD r2 <- r1 + r0 : EX->EX forward on operand A
        step(1, 2, 3, 1, 1, 1, 1, 0, 0);
        step(1, 1, 0, 1, 1, 2, 1, 0, 0);
        chk("add_add_sel_a", {30'b0, fwd_sel_a}, 2'b01);
        chk("add_add_count", {{(32-TB_CNT_W){1'b0}}, stall_count}, 0);

        // ADD r1 ; NOP ; consumer reads r1 as rt
        step(1, 2, 3, 1, 1, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 1, 1, 3, 1, 0, 0);
        chk("nop_gap_sel_b", {30'b0, fwd_sel_b}, 2'b10);
        chk("nop_gap_sel_a", {30'b0, fwd_sel_a}, 2'b00);

        // LWD r3 ; ADD reads r3 twice : one stall, then WB forward
        step(1, 0, 0, 1, 0, 3, 1, 1, 0);
        step(1, 3, 3, 1, 1, 0, 1, 0, 0);
        chk("load_use_count1", {{(32-TB_CNT_W){1'b0}}, stall_count}, 1);
        step(1, 3, 3, 1, 1, 0, 1, 0, 0);
        chk("load_use_sel_a", {30'b0, fwd_sel_a}, 2'b10);
        chk("load_use_sel_b", {30'b0, fwd_sel_b}, 2'b10);
        chk("load_use_count2", {{(32-TB_CNT_W){1'b0}}, stall_count}, 1);

        // Load-use with flush in the same cycle: flush wins
        step(1, 0, 0, 0, 0, 1, 1, 1, 0);
        step(1, 1, 1, 1, 1, 0, 1, 0, 1);
        chk("flush_count", {{(32-TB_CNT_W){1'b0}}, stall_count}, 1);
        chk("flush_sel_a", {30'b0, fwd_sel_a}, 2'b00);

        // Two writers of r2 back to back, then a reader: nearest wins
        step(1, 0, 0, 0, 0, 2, 1, 0, 0);
        step(1, 0, 0, 0, 0, 2, 1, 0, 0);
        step(1, 2, 0, 1, 0, 1, 1, 0, 0);
        chk("nearest_sel_a", {30'b0, fwd_sel_a}, 2'b01);

        // Reset pulse mid-run while a load sits in EX and a hazard is present
        step(1, 0, 0, 0, 0, 3, 1, 1, 0);
        @(negedge clk);
        id_valid = 1; id_rs = 2'd3; id_rs_used = 1; id_rt_used = 0;
        id_dest = 2'd0; id_reg_write = 1; id_mem_read = 0; flush = 0;
        #1;
        chk("pre_rst_stall", {31'b0, stall}, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_stall", {31'b0, stall}, 0);
        chk("mid_rst_sel_a", {30'b0, fwd_sel_a}, 0);
        chk("mid_rst_sel_b", {30'b0, fwd_sel_b}, 0);
        chk("mid_rst_count", {{(32-TB_CNT_W){1'b0}}, stall_count}, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step(1, 3, 3, 1, 1, 0, 1, 0, 0);
        chk("post_rst_sel_a", {30'b0, fwd_sel_a}, 0);

        // Random instruction stream
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 9) == 0);
        end

        // Saturation: a chain of dependent loads stalls every other cycle
        for (int n = 0; n < 2 * (CNT_MAX + 4); n++) begin
            step(1, 1, 0, 1, 0, 1, 1, 1, 0);
        end
        chk("sat_count", {{(32-TB_CNT_W){1'b0}}, stall_count}, CNT_MAX);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
